// File: rtl/swap_pkg.sv
// Shared types and defaults for the swap-port initiator.
package swap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WDATA  = 2'd1,
        ACCESS = 2'd2,
        GAP    = 2'd3
    } swap_state_e;

    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_GAP_CYCLES  = 2;
    localparam int DEF_MAX_BURST   = 16;

    // Width of the request length field; MAX_BURST must fit in it.
    localparam int LEN_W = 5;

    // Length 0 means one word; anything above max_len is cut back to max_len.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] max_len);
        logic [LEN_W-1:0] v;
        if (len == {LEN_W{1'b0}}) begin
            v = LEN_W'(1);
        end else if (len > max_len) begin
            v = max_len;
        end else begin
            v = len;
        end
        return v;
    endfunction

endpackage

// File: rtl/swap_hold_timer.sv
// Loadable down-counter shared by the strobe-hold and idle-gap phases.
module swap_hold_timer
    import swap_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // Count down from the loaded value and rest at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != {WIDTH{1'b0}}) begin
            r_count <= r_count - WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // done marks the last cycle of the phase, so the owner changes phase on that edge.
    assign o_done = (r_count == WIDTH'(1));

endmodule

// File: rtl/swap_initiator.sv
// Swap-port initiator: turns word bursts into fixed-length strobes with idle gaps.
module swap_initiator
    import swap_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int MAX_BURST   = DEF_MAX_BURST
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic        reqMeta,
    input  logic [31:0] reqAddress,
    input  logic [4:0]  reqLength,
    input  logic        wrValid,
    output logic        wrReady,
    input  logic [31:0] wrData,
    output logic        rdValid,
    output logic [31:0] rdData,
    output logic        rdLast,
    output logic        busy,
    output logic        swapMeta,
    output logic [31:0] swapAddress,
    output logic        swapRden,
    output logic        swapWren,
    output logic [31:0] swapData,
    input  logic [31:0] swapQ
);

    localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]    HOLD_LD = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0]    GAP_LD  = TW'(GAP_CYCLES);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

    swap_state_e      r_state;
    logic             r_write;
    logic [LEN_W-1:0] r_remaining;
    logic             r_req_ready;
    logic             r_wr_ready;
    logic             r_rd_valid;
    logic             r_rd_last;
    logic [31:0]      r_rd_data;
    logic             r_busy;
    logic             r_swap_meta;
    logic [31:0]      r_swap_address;
    logic             r_swap_rden;
    logic             r_swap_wren;
    logic [31:0]      r_swap_data;

    logic             w_tmr_load;
    logic [TW-1:0]    w_tmr_val;
    logic             w_tmr_done;
    logic [LEN_W-1:0] w_len_m1;
    logic             w_last_word;

    // r_remaining counts words still to go after the one in flight.
    assign w_len_m1    = clamp_len(reqLength, MAX_LEN) - LEN_W'(1);
    assign w_last_word = (r_remaining == {LEN_W{1'b0}});

    swap_hold_timer #(
        .WIDTH (TW)
    ) u_timer (
        .i_clk      (CLOCK_50),
        .i_rst      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // Arm the timer on every edge that enters ACCESS or GAP.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = HOLD_LD;
        case (r_state)
            IDLE: begin
                if (reqValid && !reqWrite) begin
                    w_tmr_load = 1'b1;
                end else begin
                    w_tmr_load = 1'b0;
                end
            end
            WDATA: begin
                if (wrValid) begin
                    w_tmr_load = 1'b1;
                end else begin
                    w_tmr_load = 1'b0;
                end
            end
            ACCESS: begin
                w_tmr_val = GAP_LD;
                if (w_tmr_done) begin
                    w_tmr_load = 1'b1;
                end else begin
                    w_tmr_load = 1'b0;
                end
            end
            GAP: begin
                if (w_tmr_done && !w_last_word && !r_write) begin
                    w_tmr_load = 1'b1;
                end else begin
                    w_tmr_load = 1'b0;
                end
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    // Burst sequencer; every output is a register updated alongside the state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_write        <= 1'b0;
            r_remaining    <= {LEN_W{1'b0}};
            r_req_ready    <= 1'b1;
            r_wr_ready     <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_last      <= 1'b0;
            r_rd_data      <= 32'h0000_0000;
            r_busy         <= 1'b0;
            r_swap_meta    <= 1'b0;
            r_swap_address <= 32'h0000_0000;
            r_swap_rden    <= 1'b0;
            r_swap_wren    <= 1'b0;
            r_swap_data    <= 32'h0000_0000;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (reqValid) begin
                        r_swap_meta    <= reqMeta;
                        r_swap_address <= reqAddress;
                        r_write        <= reqWrite;
                        r_remaining    <= w_len_m1;
                        r_req_ready    <= 1'b0;
                        r_busy         <= 1'b1;
                        if (reqWrite) begin
                            r_state    <= WDATA;
                            r_wr_ready <= 1'b1;
                        end else begin
                            r_state     <= ACCESS;
                            r_swap_rden <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WDATA: begin
                    if (wrValid) begin
                        r_swap_data <= wrData;
                        r_wr_ready  <= 1'b0;
                        r_swap_wren <= 1'b1;
                        r_state     <= ACCESS;
                    end else begin
                        r_state <= WDATA;
                    end
                end
                ACCESS: begin
                    if (w_tmr_done) begin
                        r_swap_rden <= 1'b0;
                        r_swap_wren <= 1'b0;
                        r_state     <= GAP;
                        if (!r_write) begin
                            r_rd_data  <= swapQ;
                            r_rd_valid <= 1'b1;
                            r_rd_last  <= w_last_word;
                        end else begin
                            r_rd_data <= r_rd_data;
                        end
                    end else begin
                        r_state <= ACCESS;
                    end
                end
                GAP: begin
                    if (w_tmr_done) begin
                        if (w_last_word) begin
                            r_state     <= IDLE;
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_remaining    <= r_remaining - LEN_W'(1);
                            r_swap_address <= r_swap_address + 32'd1;
                            if (r_write) begin
                                r_state    <= WDATA;
                                r_wr_ready <= 1'b1;
                            end else begin
                                r_state     <= ACCESS;
                                r_swap_rden <= 1'b1;
                            end
                        end
                    end else begin
                        r_state <= GAP;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_wr_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_swap_rden <= 1'b0;
                    r_swap_wren <= 1'b0;
                end
            endcase
        end
    end

    assign reqReady    = r_req_ready;
    assign wrReady     = r_wr_ready;
    assign rdValid     = r_rd_valid;
    assign rdData      = r_rd_data;
    assign rdLast      = r_rd_last;
    assign busy        = r_busy;
    assign swapMeta    = r_swap_meta;
    assign swapAddress = r_swap_address;
    assign swapRden    = r_swap_rden;
    assign swapWren    = r_swap_wren;
    assign swapData    = r_swap_data;

endmodule

// File: tb/tb_swap_initiator.sv
// Bench for swap_initiator: directed and random bursts against a queue-based access model.
module tb_swap_initiator;

    localparam int HOLD = 8;
    localparam int GAP  = 2;
    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqValid, reqReady, reqWrite, reqMeta;
    logic [31:0] reqAddress;
    logic [4:0]  reqLength;
    logic        wrValid, wrReady;
    logic [31:0] wrData;
    logic        rdValid, rdLast, busy;
    logic [31:0] rdData;
    logic        swapMeta, swapRden, swapWren;
    logic [31:0] swapAddress, swapData, swapQ;

    typedef struct {
        logic        wr;
        logic        meta;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } rd_t;

    acc_t exp_q[$];
    rd_t  rd_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    // Filesystem contents as seen on swapQ.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic int eff_len(input logic [4:0] len);
        if (len == 5'd0) return 1;
        if (int'(len) > MAXB) return MAXB;
        return int'(len);
    endfunction

    assign swapQ = mem_f(swapAddress);

    swap_initiator #(
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .MAX_BURST   (MAXB)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (reset),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqWrite    (reqWrite),
        .reqMeta     (reqMeta),
        .reqAddress  (reqAddress),
        .reqLength   (reqLength),
        .wrValid     (wrValid),
        .wrReady     (wrReady),
        .wrData      (wrData),
        .rdValid     (rdValid),
        .rdData      (rdData),
        .rdLast      (rdLast),
        .busy        (busy),
        .swapMeta    (swapMeta),
        .swapAddress (swapAddress),
        .swapRden    (swapRden),
        .swapWren    (swapWren),
        .swapData    (swapData),
        .swapQ       (swapQ)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe and read-return monitor.
    int   hold_cnt = 0;
    int   low_cnt  = 1000;
    logic in_pulse = 1'b0;

    always @(negedge clk) begin
        acc_t e;
        rd_t  r;
        if (reset) begin
            in_pulse = 1'b0;
            hold_cnt = 0;
            low_cnt  = 1000;
        end else begin
            if (swapRden || swapWren) begin
                chk("strobe_overlap", {31'd0, swapRden & swapWren}, 32'd0);
                if (!in_pulse) begin
                    in_pulse = 1'b1;
                    hold_cnt = 1;
                    chk("gap_min", {31'd0, low_cnt >= GAP}, 32'd1);
                    chk("strobe_busy", {31'd0, busy & ~reqReady}, 32'd1);
                    chk("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("strobe_dir", {31'd0, swapWren}, {31'd0, e.wr});
                        chk("swap_meta", {31'd0, swapMeta}, {31'd0, e.meta});
                        chk("swap_addr", swapAddress, e.addr);
                        if (e.wr) chk("swap_data", swapData, e.data);
                    end
                end else begin
                    hold_cnt++;
                end
            end else begin
                if (in_pulse) begin
                    chk("hold_len", hold_cnt, HOLD);
                    in_pulse = 1'b0;
                    low_cnt  = 1;
                end else if (low_cnt < 1000) begin
                    low_cnt++;
                end
            end
            if (rdValid) begin
                chk("rd_expected", {31'd0, rd_q.size() != 0}, 32'd1);
                if (rd_q.size() != 0) begin
                    r = rd_q.pop_front();
                    chk("rd_data", rdData, r.data);
                    chk("rd_last", {31'd0, rdLast}, {31'd0, r.last});
                end
            end
        end
    end

    task automatic push_burst(input logic wr, input logic meta, input logic [31:0] addr,
                              input logic [4:0] len, input logic [31:0] dbase,
                              output logic [31:0] d[MAXB]);
        int n;
        logic [31:0] a;
        n = eff_len(len);
        for (int i = 0; i < n; i++) begin
            a    = addr + 32'(i);
            d[i] = (dbase != 32'd0) ? dbase * 32'(i + 1) : $urandom;
            exp_q.push_back('{wr, meta, a, d[i]});
            if (!wr) rd_q.push_back('{mem_f(a), i == n - 1});
        end
    endtask

    task automatic wait_req_ready();
        int t = 0;
        @(negedge clk);
        while (!reqReady && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_wait", {31'd0, reqReady}, 32'd1);
    endtask

    task automatic wait_wr_ready();
        int t = 0;
        @(negedge clk);
        while (!wrReady && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wr_ready_wait", {31'd0, wrReady}, 32'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", {31'd0, busy}, 32'd0);
        chk("exp_drained", exp_q.size(), 32'd0);
        chk("rd_drained", rd_q.size(), 32'd0);
    endtask

    task automatic do_req(input logic wr, input logic meta, input logic [31:0] addr,
                          input logic [4:0] len, input logic [31:0] dbase,
                          input int stall_word, input int stall_n);
        logic [31:0] d[MAXB];
        int n;
        n = eff_len(len);
        push_burst(wr, meta, addr, len, dbase, d);
        @(posedge clk); #1;
        reqValid   = 1'b1;
        reqWrite   = wr;
        reqMeta    = meta;
        reqAddress = addr;
        reqLength  = len;
        wait_req_ready();
        @(posedge clk); #1;
        reqValid = 1'b0;
        if (wr) begin
            for (int i = 0; i < n; i++) begin
                wait_wr_ready();
                if (i == stall_word) begin
                    repeat (stall_n) @(negedge clk);
                    chk("wr_stall_hold", {31'd0, wrReady}, 32'd1);
                end
                wrData  = d[i];
                wrValid = 1'b1;
                @(posedge clk); #1;
                wrValid = 1'b0;
            end
        end
        wait_idle();
    endtask

    initial begin
        logic [31:0] d[MAXB];
        logic [31:0] a;
        reset      = 1'b1;
        reqValid   = 1'b0;
        reqWrite   = 1'b0;
        reqMeta    = 1'b0;
        reqAddress = 32'd0;
        reqLength  = 5'd0;
        wrValid    = 1'b0;
        wrData     = 32'd0;

        // Reset values.
        @(negedge clk);
        chk("rst_req_ready", {31'd0, reqReady}, 32'd1);
        chk("rst_flags", {26'd0, wrReady, rdValid, rdLast, busy, swapRden, swapWren}, 32'd0);
        chk("rst_meta", {31'd0, swapMeta}, 32'd0);
        chk("rst_addr", swapAddress, 32'd0);
        chk("rst_data", swapData, 32'd0);
        chk("rst_rddata", rdData, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single-word read with cycle-exact timing.
        push_burst(1'b0, 1'b0, 32'h0000_0100, 5'd1, 32'd0, d);
        @(posedge clk); #1;
        reqValid   = 1'b1;
        reqWrite   = 1'b0;
        reqMeta    = 1'b0;
        reqAddress = 32'h0000_0100;
        reqLength  = 5'd1;
        @(negedge clk);
        chk("t1_ready", {31'd0, reqReady}, 32'd1);
        @(posedge clk); #1;
        reqValid = 1'b0;
        for (int k = 1; k <= HOLD + GAP + 1; k++) begin
            @(negedge clk);
            chk("t1_rden", {31'd0, swapRden}, {31'd0, k <= HOLD});
            chk("t1_rdvalid", {31'd0, rdValid}, {31'd0, k == HOLD + 1});
            chk("t1_ready_back", {31'd0, reqReady}, {31'd0, k == HOLD + GAP + 1});
        end
        wait_idle();

        // Three-word metadata write with a 5-cycle data stall before word 2.
        do_req(1'b1, 1'b1, 32'h0000_0000, 5'd3, 32'h0000_0011, 1, 5);

        // Length boundaries and address wrap.
        do_req(1'b0, 1'b0, 32'h0000_2000, 5'd0, 32'd0, 0, 0);
        do_req(1'b0, 1'b1, 32'h0000_3000, 5'd31, 32'd0, 0, 0);
        do_req(1'b0, 1'b0, 32'hFFFF_FFFE, 5'd3, 32'd0, 0, 0);

        // Reset in the 4th ACCESS cycle of a write burst.
        push_burst(1'b1, 1'b0, 32'h0000_0040, 5'd3, 32'd0, d);
        @(posedge clk); #1;
        reqValid   = 1'b1;
        reqWrite   = 1'b1;
        reqAddress = 32'h0000_0040;
        reqLength  = 5'd3;
        wait_req_ready();
        @(posedge clk); #1;
        reqValid = 1'b0;
        wait_wr_ready();
        wrData  = d[0];
        wrValid = 1'b1;
        @(posedge clk); #1;
        wrValid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_wren", {31'd0, swapWren}, 32'd0);
        chk("mid_rst_rden", {31'd0, swapRden}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, reqReady}, 32'd1);
        exp_q.delete();
        rd_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_ready", {31'd0, reqReady}, 32'd1);
        do_req(1'b0, 1'b0, 32'h0000_0100, 5'd2, 32'd0, 0, 0);

        // reqValid held high: requests accepted back to back, only when idle; stray wrValid ignored.
        wrValid = 1'b1;
        wrData  = $urandom;
        @(posedge clk); #1;
        reqValid = 1'b1;
        reqWrite = 1'b0;
        for (int r = 0; r < 5; r++) begin
            reqMeta    = 1'($urandom_range(0, 1));
            reqAddress = $urandom;
            reqLength  = 5'($urandom_range(0, 4));
            wait_req_ready();
            chk("cont_idle", {31'd0, busy}, 32'd0);
            push_burst(1'b0, reqMeta, reqAddress, reqLength, 32'd0, d);
            @(posedge clk); #1;
        end
        reqValid = 1'b0;
        wait_idle();
        wrValid = 1'b0;

        // Random mixed bursts.
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else a = $urandom;
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                   5'($urandom_range(0, 31)), 32'd0,
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/swap_initiator.md
# swap_initiator

CPU-side initiator for the swap port of the HPS-backed filesystem: accepts word-granular read/write burst requests over a valid/ready interface and drives `swapMeta`/`swapAddress`/`swapRden`/`swapWren`/`swapData`, sampling `swapQ`. The HPS services the swap PIOs by polling and returns no acknowledge, so this block holds each strobe for a fixed number of cycles, then forces an idle gap so every access presents a distinct edge. It sits between the memory/MMU swap logic and the `filesystem` instance.

## Interface
- `HOLD_CYCLES`, 8: cycles each `swapRden`/`swapWren` strobe is held high; must be ≥1.
- `GAP_CYCLES`, 2: strobe-low cycles after every access; must be ≥1.
- `MAX_BURST`, 16: maximum words per request.
- `CLOCK_50`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  request accepted on the edge where both are high.
- `reqWrite`  in  1  1 = write burst, 0 = read burst.
- `reqMeta`  in  1  selects the metadata space; copied to `swapMeta`.
- `reqAddress`  in  32  first word address.
- `reqLength`  in  5  word count; 0 is treated as 1; values above `MAX_BURST` are clamped to `MAX_BURST`.
- `wrValid` / `wrReady`  in / out  1 / 1  write-data handshake.
- `wrData`  in  32  write word.
- `rdValid`  out  1  one-cycle read-data pulse; no backpressure.
- `rdData`  out  32  read word.
- `rdLast`  out  1  high with the final `rdValid` of the burst.
- `busy`  out  1  high whenever the state is not IDLE.
- `swapMeta`, `swapAddress`, `swapRden`, `swapWren`, `swapData`  out  1/32/1/1/32  swap port drive.
- `swapQ`  in  32  swap read data from the filesystem.

## Operation
- States:
  - IDLE: `reqReady` = 1.
  - WDATA: write only; `wrReady` = 1.
  - ACCESS: strobe high for `HOLD_CYCLES` cycles.
  - GAP: strobe low for `GAP_CYCLES` cycles.
- IDLE → ACCESS (read) or WDATA (write) on request handshake. The handshake latches `reqMeta` and `reqAddress`, and loads the remaining-word count.
- WDATA → ACCESS on `wrValid & wrReady`; `wrData` is registered into `swapData`.
- ACCESS → GAP when the hold counter expires.
- On a read, `swapQ` is registered into `rdData` on the edge that ends ACCESS.
- GAP → IDLE when the gap counter expires and no words remain. Otherwise `swapAddress` increments by 1 (modulo 2^32; 0xFFFFFFFF wraps to 0) and GAP → ACCESS (read) or WDATA (write).
- `swapMeta` and `swapAddress` are stable for the whole request, except for the address increment during GAP.
- `swapRden` and `swapWren` are never high together. Both are high only in ACCESS.
- Only one request is outstanding at a time; `reqValid` outside IDLE is ignored (`reqReady` = 0).
- `wrValid` outside WDATA is ignored.
- Reset, including mid-burst, takes effect immediately (asynchronous): state = IDLE, strobes drop with no completion of the access, and any partial burst is discarded.
- Reset values:
  - `reqReady` = 1.
  - `wrReady`, `rdValid`, `rdLast`, `busy`, `swapMeta`, `swapRden`, `swapWren` = 0.
  - `swapAddress`, `swapData`, `rdData` = 0.

## Timing
- Request accepted at edge E0. ACCESS occupies cycles E0+1 … E0+HOLD_CYCLES.
- Read: `rdValid` is high in the first GAP cycle, E0+HOLD_CYCLES+1 (latency HOLD_CYCLES+1).
- Per-word period:
  - Read: HOLD_CYCLES+GAP_CYCLES.
  - Write: HOLD_CYCLES+GAP_CYCLES+1 minimum, plus any stall while `wrValid` is low.
- `reqReady` reasserts in the cycle after the last GAP cycle. Back-to-back requests are accepted that cycle.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Structure
- Package `swap_pkg` holds:
  - the state enum (IDLE, WDATA, ACCESS, GAP);
  - default `HOLD_CYCLES` / `GAP_CYCLES` / `MAX_BURST` constants;
  - the length clamp width.
- Sub-module `swap_hold_timer`: a loadable down-counter with a `done` flag, reused for both the HOLD and GAP phases. Its width covers max(HOLD_CYCLES, GAP_CYCLES).

## Test plan
- Read 1 word, meta=0, addr 0x100, `swapQ` = 0xDEADBEEF: `swapRden` high for exactly 8 cycles; `rdValid` at E0+9 with `rdData` = 0xDEADBEEF and `rdLast` = 1; `reqReady` back at E0+11.
- Write 3 words, meta=1, addr 0x0, data 0x11/0x22/0x33 with `wrValid` withheld 5 cycles before the second word: three 8-cycle `swapWren` pulses at addresses 0, 1, 2 with matching `swapData`; WDATA stalls for 5 cycles; `swapMeta` = 1 throughout.
- Read, length 0 → 1 word; length 31 → 16 words. Address 0xFFFFFFFE, length 3 → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0; `rdLast` only on the third word.
- Assert `reset` in the 4th ACCESS cycle of a write burst: strobes drop in the same cycle; after release, `busy` = 0 and `reqReady` = 1; the next read is serviced normally.
- Hold `reqValid` high continuously: a new request is accepted only in IDLE cycles; `swapRden` and `swapWren` are never simultaneously high; there are never fewer than 2 low cycles between strobes.
